vx_lsu_commit_merge: RTL and testbench



---
 rtl/vx_lsu_commit_merge_pkg.sv | 22 ++
 rtl/vx_commit_fifo.sv | 52 +++++
 rtl/vx_lsu_commit_merge.sv | 168 ++++++++++++++++
 tb/tb_vx_lsu_commit_merge.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_lsu_commit_merge_pkg.sv
// Shared types and defaults for the LSU commit merge block.
// commit_entry_t matches the default lane/warp/register widths.
package vx_lsu_commit_merge_pkg;

  localparam int DEF_NUM_THREADS  = 4;
  localparam int DEF_NW_BITS      = 2;
  localparam int DEF_NR_BITS      = 5;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_OBUF_DEPTH   = 2;

  typedef struct packed {
    logic [DEF_NW_BITS-1:0]        wid;
    logic [DEF_NUM_THREADS-1:0]    tmask;
    logic [31:0]                   pc;
    logic [DEF_NR_BITS-1:0]        rd;
    logic                          wb;
    logic                          eop;
    logic [DEF_NUM_THREADS*32-1:0] data;
    logic                          is_store;
  } commit_entry_t;

endpackage

// File: rtl/vx_commit_fifo.sv
// Output buffer for the commit merge: power-of-two circular FIFO.
// Pointers wrap naturally; storage is not reset, only control state is.
module vx_commit_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vx_lsu_commit_merge.sv
// Merges LSU load/store commit streams into one buffered commit stream.
// Optional LSU_COMMIT_PERF_EN adds load/store/stall perf counters.
module vx_lsu_commit_merge
  import vx_lsu_commit_merge_pkg::*;
#(
  parameter int NUM_THREADS  = DEF_NUM_THREADS,
  parameter int NW_BITS      = DEF_NW_BITS,
  parameter int NR_BITS      = DEF_NR_BITS,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int OBUF_DEPTH   = DEF_OBUF_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [NW_BITS-1:0]          ld_wid,
  input  logic [NUM_THREADS-1:0]      ld_tmask,
  input  logic [31:0]                 ld_pc,
  input  logic [NR_BITS-1:0]          ld_rd,
  input  logic                        ld_wb,
  input  logic                        ld_eop,
  input  logic [NUM_THREADS*32-1:0]   ld_data,
  input  logic                        st_valid,
  output logic                        st_ready,
  input  logic [NW_BITS-1:0]          st_wid,
  input  logic [NUM_THREADS-1:0]      st_tmask,
  input  logic [31:0]                 st_pc,
  output logic                        cm_valid,
  input  logic                        cm_ready,
  output logic [NW_BITS-1:0]          cm_wid,
  output logic [NUM_THREADS-1:0]      cm_tmask,
  output logic [31:0]                 cm_pc,
  output logic [NR_BITS-1:0]          cm_rd,
  output logic                        cm_wb,
  output logic                        cm_eop,
  output logic [NUM_THREADS*32-1:0]   cm_data,
  output logic                        cm_is_store
`ifdef LSU_COMMIT_PERF_EN
  ,
  output logic [63:0]                 perf_ld_beats,
  output logic [63:0]                 perf_st_commits,
  output logic [63:0]                 perf_stall_cycles
`endif
);

  localparam int CNT_W = $clog2(OBUF_DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [NW_BITS-1:0]        wid;
    logic [NUM_THREADS-1:0]    tmask;
    logic [31:0]               pc;
    logic [NR_BITS-1:0]        rd;
    logic                      wb;
    logic                      eop;
    logic [NUM_THREADS*32-1:0] data;
    logic                      is_store;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic              lock;
  logic [SC_W-1:0]   starve_cnt;
  logic              starve_hit;
  logic              space;
  logic              gnt_ld;
  logic              gnt_st;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  occ;
  entry_t            push_entry;
  entry_t            head_entry;
  entry_t            cm_entry;

  // Grant stage: ready derives from registered occupancy only, never cm_ready
  assign space      = reset_n && (occ < CNT_W'(OBUF_DEPTH));
  assign starve_hit = (starve_cnt == SC_W'(STARVE_LIMIT));
  assign gnt_ld     = space && ld_valid && (lock || !(starve_hit && st_valid));
  assign gnt_st     = space && !lock && st_valid && (starve_hit || !ld_valid);
  assign ld_ready   = gnt_ld;
  assign st_ready   = gnt_st;
  assign push       = gnt_ld || gnt_st;
  assign pop        = cm_valid && cm_ready;

  always_comb begin
    push_entry = '0;
    if (gnt_st) begin
      push_entry.wid      = st_wid;
      push_entry.tmask    = st_tmask;
      push_entry.pc       = st_pc;
      push_entry.eop      = 1'b1;
      push_entry.is_store = 1'b1;
    end else begin
      push_entry.wid      = ld_wid;
      push_entry.tmask    = ld_tmask;
      push_entry.pc       = ld_pc;
      push_entry.rd       = ld_rd;
      push_entry.wb       = ld_wb;
      push_entry.eop      = ld_eop;
      push_entry.data     = ld_data;
    end
  end

  // Lock keeps multi-beat load responses contiguous
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock <= 1'b0;
    end else if (gnt_ld) begin
      lock <= !ld_eop;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (fifo_full) begin
      starve_cnt <= starve_cnt;
    end else if (!st_valid || gnt_st) begin
      starve_cnt <= '0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  // Buffer stage: head of FIFO drives the commit interface
  vx_commit_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (OBUF_DEPTH)
  ) u_obuf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occ)
  );

  assign cm_valid    = !fifo_empty;
  assign cm_entry    = fifo_empty ? '0 : head_entry;
  assign cm_wid      = cm_entry.wid;
  assign cm_tmask    = cm_entry.tmask;
  assign cm_pc       = cm_entry.pc;
  assign cm_rd       = cm_entry.rd;
  assign cm_wb       = cm_entry.wb;
  assign cm_eop      = cm_entry.eop;
  assign cm_data     = cm_entry.data;
  assign cm_is_store = cm_entry.is_store;

`ifdef LSU_COMMIT_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_ld_beats     <= '0;
      perf_st_commits   <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (gnt_ld)                perf_ld_beats     <= perf_ld_beats + 64'd1;
      if (gnt_st)                perf_st_commits   <= perf_st_commits + 64'd1;
      if (cm_valid && !cm_ready) perf_stall_cycles <= perf_stall_cycles + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_lsu_commit_merge.sv
// Scoreboard bench for vx_lsu_commit_merge: directed steps, queued expectations.
module tb_vx_lsu_commit_merge;
  import vx_lsu_commit_merge_pkg::*;

  localparam int DEPTH = 2;

  logic          clk;
  logic          reset_n;
  logic          ld_valid, ld_ready;
  logic [1:0]    ld_wid;
  logic [3:0]    ld_tmask;
  logic [31:0]   ld_pc;
  logic [4:0]    ld_rd;
  logic          ld_wb, ld_eop;
  logic [127:0]  ld_data;
  logic          st_valid, st_ready;
  logic [1:0]    st_wid;
  logic [3:0]    st_tmask;
  logic [31:0]   st_pc;
  logic          cm_valid, cm_ready;
  logic [1:0]    cm_wid;
  logic [3:0]    cm_tmask;
  logic [31:0]   cm_pc;
  logic [4:0]    cm_rd;
  logic          cm_wb, cm_eop;
  logic [127:0]  cm_data;
  logic          cm_is_store;
`ifdef LSU_COMMIT_PERF_EN
  logic [63:0]   perf_ld_beats, perf_st_commits, perf_stall_cycles;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vx_lsu_commit_merge dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_wid      (ld_wid),
    .ld_tmask    (ld_tmask),
    .ld_pc       (ld_pc),
    .ld_rd       (ld_rd),
    .ld_wb       (ld_wb),
    .ld_eop      (ld_eop),
    .ld_data     (ld_data),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_wid      (st_wid),
    .st_tmask    (st_tmask),
    .st_pc       (st_pc),
    .cm_valid    (cm_valid),
    .cm_ready    (cm_ready),
    .cm_wid      (cm_wid),
    .cm_tmask    (cm_tmask),
    .cm_pc       (cm_pc),
    .cm_rd       (cm_rd),
    .cm_wb       (cm_wb),
    .cm_eop      (cm_eop),
    .cm_data     (cm_data),
    .cm_is_store (cm_is_store)
`ifdef LSU_COMMIT_PERF_EN
    ,
    .perf_ld_beats     (perf_ld_beats),
    .perf_st_commits   (perf_st_commits),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  commit_entry_t cm_ent;
  assign cm_ent = {cm_wid, cm_tmask, cm_pc, cm_rd, cm_wb, cm_eop, cm_data, cm_is_store};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_pop, n_acc, first_pop, last_pop, first_acc;
  logic [31:0] hist;
  bit ld_en, st_en;
  commit_entry_t exp_q[$];
  commit_entry_t ld_q[$];
  commit_entry_t st_q[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic commit_entry_t mk_ld(input int wid, input bit eop, input int seed);
    commit_entry_t e;
    e.wid      = 2'(wid);
    e.tmask    = 4'(seed + 1);
    e.pc       = 32'h1000 + 32'(seed) * 4;
    e.rd       = 5'(seed + 1);
    e.wb       = 1'b1;
    e.eop      = eop;
    e.data     = {4{32'hA500_0000 + 32'(seed)}};
    e.is_store = 1'b0;
    return e;
  endfunction

  function automatic commit_entry_t mk_st(input int seed);
    commit_entry_t e;
    e.wid      = 2'(seed);
    e.tmask    = 4'(seed + 3);
    e.pc       = 32'h2000 + 32'(seed) * 4;
    e.rd       = 5'h1F;
    e.wb       = 1'b1;
    e.eop      = 1'b0;
    e.data     = '1;
    e.is_store = 1'b0;
    return e;
  endfunction

  task automatic drive();
    if (ld_en && ld_q.size() > 0) begin
      ld_valid = 1'b1;
      ld_wid   = ld_q[0].wid;
      ld_tmask = ld_q[0].tmask;
      ld_pc    = ld_q[0].pc;
      ld_rd    = ld_q[0].rd;
      ld_wb    = ld_q[0].wb;
      ld_eop   = ld_q[0].eop;
      ld_data  = ld_q[0].data;
    end else begin
      ld_valid = 1'b0;
    end
    if (st_en && st_q.size() > 0) begin
      st_valid = 1'b1;
      st_wid   = st_q[0].wid;
      st_tmask = st_q[0].tmask;
      st_pc    = st_q[0].pc;
    end else begin
      st_valid = 1'b0;
    end
  endtask

  task automatic clear_stats();
    n_pop = 0; n_acc = 0; first_pop = 0; last_pop = 0; first_acc = 0; hist = '0;
  endtask

  task automatic tick();
    commit_entry_t e;
    @(negedge clk);
    cyc++;
    if (cm_valid && cm_ready) begin
      n_pop++;
      if (n_pop == 1) first_pop = cyc;
      last_pop = cyc;
      hist = {hist[30:0], cm_is_store};
      chk("sb_has_entry", 256'(exp_q.size() > 0), 256'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("payload", 256'(cm_ent), 256'(e));
      end
    end
    if (ld_valid && ld_ready) begin
      n_acc++;
      if (n_acc == 1) first_acc = cyc;
      exp_q.push_back(ld_q.pop_front());
    end
    if (st_valid && st_ready) begin
      n_acc++;
      if (n_acc == 1) first_acc = cyc;
      e = st_q.pop_front();
      e.rd = '0; e.wb = 1'b0; e.eop = 1'b1; e.data = '0; e.is_store = 1'b1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((exp_q.size() > 0 || ld_q.size() > 0 || st_q.size() > 0) && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, 256'(exp_q.size() + ld_q.size() + st_q.size()), 256'(0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ld_q.delete(); st_q.delete(); exp_q.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive();
  endtask

  initial begin
    reset_n = 1'b0; cm_ready = 1'b0; ld_en = 1'b0; st_en = 1'b0;
    ld_wid = '0; ld_tmask = '0; ld_pc = '0; ld_rd = '0; ld_wb = 1'b0; ld_eop = 1'b0; ld_data = '0;
    st_wid = '0; st_tmask = '0; st_pc = '0;
    clear_stats();
    drive();
    ld_valid = 1'b1;
    st_valid = 1'b1;
    #12;
    chk("rst_cm_valid", 256'(cm_valid), 256'(0));
    chk("rst_ld_ready", 256'(ld_ready), 256'(0));
    chk("rst_st_ready", 256'(st_ready), 256'(0));
    chk("rst_cm_data",  256'(cm_data),  256'(0));
    chk("rst_cm_pc",    256'(cm_pc),    256'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive();
    tick();
    chk("post_rst_empty", 256'(cm_valid), 256'(0));

    // 8 back-to-back single-beat loads, wid=1
    clear_stats();
    cm_ready = 1'b1; ld_en = 1'b1; st_en = 1'b0;
    for (int i = 0; i < 8; i++) ld_q.push_back(mk_ld(1, 1'b1, i));
    drive();
    drain("t1", 40);
    chk("t1_pops",    256'(n_pop), 256'(8));
    chk("t1_latency", 256'(first_pop - first_acc), 256'(1));
    chk("t1_consec",  256'(last_pop - first_pop), 256'(7));
    chk("t1_no_store", 256'(hist[7:0]), 256'(0));

    // Both sources always valid: 4 loads then 1 store
    clear_stats();
    st_en = 1'b1;
    for (int i = 0; i < 10; i++) ld_q.push_back(mk_ld(2, 1'b1, 20 + i));
    for (int i = 0; i < 2; i++)  st_q.push_back(mk_st(40 + i));
    drive();
    drain("t2", 60);
    chk("t2_pops",  256'(n_pop), 256'(12));
    chk("t2_order", 256'(hist[11:0]), 256'(12'b0000_1000_0100));

    // 3-beat load, store raised on beat 1
    clear_stats();
    st_en = 1'b0;
    ld_q.push_back(mk_ld(3, 1'b0, 50));
    ld_q.push_back(mk_ld(3, 1'b0, 51));
    ld_q.push_back(mk_ld(3, 1'b1, 52));
    st_q.push_back(mk_st(53));
    drive();
    tick();
    st_en = 1'b1;
    drive();
    drain("t3a", 30);
    chk("t3a_order",  256'(hist[3:0]), 256'(4'b0001));
    chk("t3a_consec", 256'(last_pop - first_pop), 256'(3));

    // 7-beat load outlasts the starvation limit; store follows, then a new load
    clear_stats();
    st_en = 1'b0;
    for (int i = 0; i < 6; i++) ld_q.push_back(mk_ld(0, 1'b0, 60 + i));
    ld_q.push_back(mk_ld(0, 1'b1, 66));
    ld_q.push_back(mk_ld(1, 1'b1, 67));
    st_q.push_back(mk_st(68));
    drive();
    tick();
    st_en = 1'b1;
    drive();
    drain("t3b", 40);
    chk("t3b_order", 256'(hist[8:0]), 256'(9'b000000010));

    // Commit side stalled for 10 cycles
    clear_stats();
    cm_ready = 1'b0;
    for (int i = 0; i < 4; i++) ld_q.push_back(mk_ld(2, 1'b1, 70 + i));
    for (int i = 0; i < 3; i++) st_q.push_back(mk_st(80 + i));
    drive();
    repeat (10) tick();
    chk("t4_accepted", 256'(exp_q.size()), 256'(DEPTH));
    chk("t4_cm_valid", 256'(cm_valid), 256'(1));
    cm_ready = 1'b1;
    drain("t4", 60);
    chk("t4_pops", 256'(n_pop), 256'(7));

    // Asynchronous reset in the middle of a locked burst
    clear_stats();
    st_en = 1'b0;
    for (int i = 0; i < 4; i++) ld_q.push_back(mk_ld(1, 1'b0, 90 + i));
    drive();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_cm_valid", 256'(cm_valid), 256'(0));
    chk("t5_rst_ld_ready", 256'(ld_ready), 256'(0));
    chk("t5_rst_st_ready", 256'(st_ready), 256'(0));
    ld_q.delete(); st_q.delete(); exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive();
    tick();
    chk("t5_empty_after", 256'(cm_valid), 256'(0));
    clear_stats();
    st_en = 1'b1;
    st_q.push_back(mk_st(100));
    drive();
    drain("t5_lock", 10);
    chk("t5_store_out", 256'(hist[0]), 256'(1));
    clear_stats();
    ld_q.push_back(mk_ld(2, 1'b1, 101));
    drive();
    drain("t5_ld", 10);
    chk("t5_latency", 256'(first_pop - first_acc), 256'(1));

`ifdef LSU_COMMIT_PERF_EN
    // Perf counters: 5 loads, 2 stores, 3 stall cycles
    do_reset();
    clear_stats();
    cm_ready = 1'b0; ld_en = 1'b1; st_en = 1'b1;
    ld_q.push_back(mk_ld(1, 1'b1, 110));
    drive();
    tick();
    repeat (3) tick();
    cm_ready = 1'b1;
    for (int i = 0; i < 4; i++) ld_q.push_back(mk_ld(1, 1'b1, 111 + i));
    for (int i = 0; i < 2; i++) st_q.push_back(mk_st(120 + i));
    drive();
    drain("t6", 40);
    chk("perf_ld_beats",     256'(perf_ld_beats),     256'(5));
    chk("perf_st_commits",   256'(perf_st_commits),   256'(2));
    chk("perf_stall_cycles", 256'(perf_stall_cycles), 256'(3));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
